// File: rtl/mseq_transmitter.sv
// PN chip transmitter: Fibonacci LFSR m-sequence sent serially for reps periods.
// Ports: clk/nRst, start/stop/seed/reps in; chip stream, strobes, status, code_word out.
module mseq_transmitter #(
  parameter int LFSR_LEN = 3,
  parameter logic [LFSR_LEN-1:0] TAPS = 3'b110,
  parameter int CHIP_DIV = 1,
  parameter int REPS_W = 4,
  localparam int P = 2**LFSR_LEN - 1
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic                start,
  input  logic                stop,
  input  logic [LFSR_LEN-1:0] seed,
  input  logic [REPS_W-1:0]   reps,
  output logic                chip_out,
  output logic                chip_strobe,
  output logic                frame_start,
  output logic                busy,
  output logic                done,
  output logic                seed_err,
  output logic [P-1:0]        code_word
);

  localparam int DIV_W = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CHIP_DIV - 1);
  localparam logic [LFSR_LEN-1:0] CHIP_LAST = LFSR_LEN'(P - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [LFSR_LEN-1:0] lfsr;
  logic [LFSR_LEN-1:0] chip;
  logic [DIV_W-1:0]    div;
  logic [REPS_W-1:0]   rep_cnt;
  logic [P-1:0]        code_sr;

  logic fb;
  logic cur;
  logic go;
  logic chip_end;
  logic per_end;
  logic last_per;

  assign fb  = ^(lfsr & TAPS);
  assign cur = lfsr[LFSR_LEN-1];
  assign go  = (state == IDLE) && start && (seed != '0);

  assign chip_end = (state == RUN) && (div == DIV_LAST);
  assign per_end  = chip_end && (chip == CHIP_LAST);
  // rep_cnt==0 means continuous, so only a count of 1 ends the run
  assign last_per = per_end && (rep_cnt == REPS_W'(1));

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (go) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (stop)          state_nxt = IDLE;
        else if (last_per) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign chip_out    = busy & cur;
  assign chip_strobe = busy & (div == '0);
  assign frame_start = chip_strobe & (chip == '0);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      lfsr      <= '0;
      chip      <= '0;
      div       <= '0;
      rep_cnt   <= '0;
      code_sr   <= '0;
      code_word <= '0;
      seed_err  <= 1'b0;
    end else begin
      seed_err <= (state == IDLE) && start && (seed == '0);
      if (go) begin
        lfsr    <= seed;
        rep_cnt <= reps;
        div     <= '0;
        chip    <= '0;
      end else if (state == RUN && !stop) begin
        if (chip_end) begin
          div     <= '0;
          lfsr    <= {lfsr[LFSR_LEN-2:0], fb};
          code_sr <= {code_sr[P-2:0], cur};
          if (per_end) begin
            chip      <= '0;
            code_word <= {code_sr[P-2:0], cur};
            if (rep_cnt != '0)
              rep_cnt <= rep_cnt - 1'b1;
          end else begin
            chip <= chip + 1'b1;
          end
        end else begin
          div <= div + 1'b1;
        end
      end
    end
  end

endmodule
